addsub_serial_nb: RTL and testbench

- Parametrised, digit-serial adder/subtractor; successor to the fixed 4-bit ripple adder.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, so one small ripple slice is reused over WIDTH/DIGIT cycles.
- Adds subtract mode, signed overflow detection and a start/busy/done handshake.
- Sits between the ALU operand registers and the result mux.

---
 rtl/addsub_serial_nb.sv | 136 +++++++++++++
 tb/tb_addsub_serial_nb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_nb.sv
// addsub_serial_nb: digit-serial adder/subtractor.
// A WIDTH-bit operand pair is consumed DIGIT bits per clock, LSB digit first,
// over N = WIDTH/DIGIT cycles through one DIGIT-bit ripple slice.
// Optional macro ADDSUB_SAT_EN: saturate o_sum on signed overflow.
module addsub_serial_nb #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;     // A, shifted right one digit per step
  logic [WIDTH-1:0] b_q, b_d;     // B' (B or ~B), shifted likewise
  logic [WIDTH-1:0] res_q, res_d; // partial result, digits enter at the top
  logic             c_q, c_d;     // running carry between digits
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   slice;
  logic             c_msb;
  logic             ovf_w;
  logic [WIDTH-1:0] res_next;

  // Ripple slice on the current low digit; carry into the slice MSB recovered
  // from the sum bit so overflow works for any DIGIT, including 1.
  always_comb begin
    slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    c_msb    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
    ovf_w    = c_msb ^ slice[DIGIT];
    res_next = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Next-state, datapath and result registration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_bit1;
          b_d     = i_sub ? ~i_bit2 : i_bit2;
          c_d     = i_sub ^ i_carry;       // sub: borrow-in becomes ~carry-in
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = slice[DIGIT];
        res_d = res_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_next;
          cout_d  = slice[DIGIT];
          ovf_d   = ovf_w;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef ADDSUB_SAT_EN
          // On the last digit a_q[DIGIT-1] is the original A sign bit.
          if (ovf_w) sum_d = a_q[DIGIT-1] ? SMIN : SMAX;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; synchronous reset aborts any operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_carry = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_serial_nb.sv
// tb_addsub_serial_nb: randomized + directed bench for addsub_serial_nb,
// instances at DIGIT=4 (N=4) and DIGIT=16 (N=1), checked against an
// integer-arithmetic reference model.
module tb_addsub_serial_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        s1_start = 1'b0, s1_sub = 1'b0, s1_cin = 1'b0;
  logic [15:0] s1_a = '0, s1_b = '0;
  logic        s1_busy, s1_done, s1_cout, s1_ovf;
  logic [15:0] s1_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_serial_nb #(.WIDTH(16), .DIGIT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub), .i_carry(cin),
    .i_bit1(a), .i_bit2(b), .o_busy(busy), .o_done(done), .o_sum(sum),
    .o_carry(cout), .o_ovf(ovf));

  addsub_serial_nb #(.WIDTH(16), .DIGIT(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1_start), .i_sub(s1_sub), .i_carry(s1_cin),
    .i_bit1(s1_a), .i_bit2(s1_b), .o_busy(s1_busy), .o_done(s1_done), .o_sum(s1_sum),
    .o_carry(s1_cout), .o_ovf(s1_ovf));

  // Reference: plain integer add / subtract, range test for signed overflow.
  // Returns {ovf, carry, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, y, input logic s, c);
    int ur, sr;
    logic [15:0] r;
    logic co, ov;
    if (!s) begin
      ur = int'(x) + int'(y) + int'(c);
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
      co = (ur > 65535);
    end else begin
      ur = int'(x) - int'(y) - int'(c);
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
      co = (ur >= 0);
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (ov) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {ov, co, r};
  endfunction

  // Launch one op on the N=4 instance and measure it; returns at the
  // falling edge of the done cycle. inj>=0 pulses a stray start in that cycle.
  task automatic run_op(input logic [15:0] ai, bi, input logic si, ci, input int inj,
                        output int lat, output int busy_n, output logic held_ok,
                        output logic [17:0] held);
    a = ai; b = bi; sub = si; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = -1; busy_n = 0; held_ok = 1'b1; held = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == inj) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      if (k == 0) held = {ovf, cout, sum};
      if (done) begin lat = k; break; end
      if (busy) busy_n++;
      if ({ovf, cout, sum} !== held) held_ok = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (sum !== 16'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", cout); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if ({s1_busy, s1_done, s1_sum, s1_cout, s1_ovf} !== 19'h0) begin
      bad++; $display("FAIL reset_d16 got=%h exp=0", {s1_busy, s1_done, s1_sum, s1_cout, s1_ovf}); end
  endtask

  task automatic test_directed;
    logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, bn; logic hok; logic [17:0] hv, e;
    for (int i = 0; i < 5; i++) begin
      e = model(ta[i], tb[i], ts[i], 1'b0);
      run_op(ta[i], tb[i], ts[i], 1'b0, -1, lat, bn, hok, hv);
      total++; if (lat !== 4) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
      total++; if (bn !== 4) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=4", i, bn); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, busy); end
      total++; if ({ovf, cout, sum} !== e) begin
        bad++; $display("FAIL dir%0d_result got=%b/%b/%h exp=%b/%b/%h", i, ovf, cout, sum, e[17], e[16], e[15:0]); end
      @(posedge clk); #1; @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_ignore_start;
    int lat, bn, extra; logic hok; logic [17:0] hv, e;
    e = model(16'hA5A5, 16'h1111, 1'b1, 1'b1);
    run_op(16'hA5A5, 16'h1111, 1'b1, 1'b1, 2, lat, bn, hok, hv);
    total++; if (lat !== 4) begin bad++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    total++; if ({ovf, cout, sum} !== e) begin
      bad++; $display("FAIL ign_result got=%b/%b/%h exp=%b/%b/%h", ovf, cout, sum, e[17], e[16], e[15:0]); end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1; @(negedge clk);
      if (done || busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_activity got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bn; logic hok; logic [17:0] hv, e1, e2;
    e1 = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    e2 = model(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, -1, lat, bn, hok, hv);
    total++; if ({ovf, cout, sum} !== e1) begin
      bad++; $display("FAIL b2b_first got=%b/%b/%h exp=%b/%b/%h", ovf, cout, sum, e1[17], e1[16], e1[15:0]); end
    run_op(16'h0F0F, 16'hF0F0, 1'b0, 1'b1, -1, lat, bn, hok, hv);
    total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    total++; if (hv !== e1) begin bad++; $display("FAIL b2b_held_value got=%h exp=%h", hv, e1); end
    total++; if (hok !== 1'b1) begin bad++; $display("FAIL b2b_held_stable got=%b exp=1", hok); end
    total++; if ({ovf, cout, sum} !== e2) begin
      bad++; $display("FAIL b2b_second got=%b/%b/%h exp=%b/%b/%h", ovf, cout, sum, e2[17], e2[16], e2[15:0]); end
  endtask

  task automatic test_reset_mid;
    int lat, bn, seen; logic hok; logic [17:0] hv;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, -1, lat, bn, hok, hv);
    total++; if (sum !== 16'h5555) begin bad++; $display("FAIL rmid_setup got=%h exp=5555", sum); end
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // accepted; first RUN cycle
    @(posedge clk); #1 rst = 1'b1;     // second RUN cycle
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      bad++; $display("FAIL rmid_cleared got=%h exp=0", {busy, done, sum, cout, ovf}); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1; @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_random;
    logic [15:0] sp [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] x, y; logic s, c;
    int lat, bn, nbad; logic hok; logic [17:0] hv, e;
    nbad = 0;
    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 16'($urandom);
      s = 1'($urandom); c = 1'($urandom);
      e = model(x, y, s, c);
      run_op(x, y, s, c, -1, lat, bn, hok, hv);
      total++;
      if (lat !== 4 || {ovf, cout, sum} !== e) begin
        bad++; nbad++;
        $display("FAIL rand%0d %h %s %h c=%b lat=%0d got=%b/%b/%h exp=%b/%b/%h", i, x, s ? "-" : "+", y, c,
                 lat, ovf, cout, sum, e[17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_digit16;
    logic [15:0] x, y; logic s, c; logic [17:0] e; int lat;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin x = 16'h7FFF; y = 16'h0001; s = 1'b0; c = 1'b0; end
      else if (i == 1) begin x = 16'h8000; y = 16'h0001; s = 1'b1; c = 1'b0; end
      else begin x = 16'($urandom); y = 16'($urandom); s = 1'($urandom); c = 1'($urandom); end
      e = model(x, y, s, c);
      s1_a = x; s1_b = y; s1_sub = s; s1_cin = c; s1_start = 1'b1;
      @(posedge clk); #1 s1_start = 1'b0;
      lat = -1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (s1_done) begin lat = k; break; end
        @(posedge clk); #1;
      end
      total++; if (lat !== 1) begin bad++; $display("FAIL d16_%0d_latency got=%0d exp=1", i, lat); end
      total++; if ({s1_ovf, s1_cout, s1_sum} !== e) begin
        bad++; $display("FAIL d16_%0d_result got=%b/%b/%h exp=%b/%b/%h", i, s1_ovf, s1_cout, s1_sum,
                        e[17], e[16], e[15:0]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_digit16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
